traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_ctrl.sv | 139 +++++++++++++
 tb/tb_traffic_light_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Three-phase traffic light sequencer (RED -> GREEN -> YELLOW) advanced by upstream timer ticks.
// Pedestrian request logic is compiled only when TRAFFIC_LIGHT_CTRL_PED_REQ_EN is defined.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int RED_TICKS    = 6,
  parameter int GREEN_MIN    = 2,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ped_req,
  output logic red,
  output logic yellow,
  output logic green,
  output logic phase_end,
  output logic ped_ack
);

  localparam int MAX_TICKS =
    (GREEN_TICKS > YELLOW_TICKS) ?
      ((GREEN_TICKS > RED_TICKS) ? GREEN_TICKS : RED_TICKS) :
      ((YELLOW_TICKS > RED_TICKS) ? YELLOW_TICKS : RED_TICKS);

  if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || RED_TICKS < 1) begin : g_bad_ticks
    $error("traffic_light_ctrl: all phase lengths must be at least 1 tick");
  end
  if (GREEN_MIN < 1 || GREEN_MIN > GREEN_TICKS) begin : g_bad_min
    $error("traffic_light_ctrl: GREEN_MIN must lie in 1..GREEN_TICKS");
  end
  if ((2 ** CNT_W) <= MAX_TICKS) begin : g_bad_width
    $error("traffic_light_ctrl: CNT_W too narrow for the longest phase");
  end

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);

  typedef enum logic [1:0] {
    RED,
    GREEN,
    YELLOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  logic             advance;

`ifdef TRAFFIC_LIGHT_CTRL_PED_REQ_EN
  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);

  logic pend_q, pend_d;
  logic ack_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last    = 1'b0;
    advance = 1'b0;
`ifdef TRAFFIC_LIGHT_CTRL_PED_REQ_EN
    pend_d  = pend_q;
    ack_d   = 1'b0;
`endif

    case (state_q)
      RED:    last = (cnt_q == RED_LAST);
      GREEN: begin
        last = (cnt_q == GREEN_LAST);
`ifdef TRAFFIC_LIGHT_CTRL_PED_REQ_EN
        // A served-later request may cut green short once the minimum has elapsed.
        if (pend_q && cnt_q >= GREEN_MIN_LAST) last = 1'b1;
`endif
      end
      YELLOW: last = (cnt_q == YELLOW_LAST);
      default: last = 1'b1;
    endcase

    if (tick) begin
      if (last) begin
        advance = 1'b1;
        cnt_d   = '0;
        case (state_q)
          RED:     state_d = GREEN;
          GREEN:   state_d = YELLOW;
          default: state_d = RED;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef TRAFFIC_LIGHT_CTRL_PED_REQ_EN
    if (advance && state_q == YELLOW && pend_q) begin
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end else if (ped_req && !pend_q && state_q != RED) begin
      pend_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RED;
      cnt_q     <= '0;
      red       <= 1'b1;
      yellow    <= 1'b0;
      green     <= 1'b0;
      phase_end <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      red       <= (state_d == RED);
      yellow    <= (state_d == YELLOW);
      green     <= (state_d == GREEN);
      phase_end <= advance;
    end
  end

`ifdef TRAFFIC_LIGHT_CTRL_PED_REQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      ped_ack <= ack_d;
    end
  end
`else
  logic ped_req_unused;
  assign ped_req_unused = ped_req;
  assign ped_ack        = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Vector-table bench for traffic_light_ctrl; expected outputs queued at drive time, compared after each edge.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic ped_req = 1'b0;
  logic red, yellow, green, phase_end, ped_ack;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .GREEN_TICKS (8),
    .YELLOW_TICKS(2),
    .RED_TICKS   (6),
    .GREEN_MIN   (2),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .ped_req  (ped_req),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .phase_end(phase_end),
    .ped_ack  (ped_ack)
  );

  typedef struct {
    logic       rst;
    logic       tick;
    logic       ped;
    logic [4:0] exp;   // {red, yellow, green, phase_end, ped_ack}
    string      nm;
  } vec_t;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  vec_t tbl[$];
  vec_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned vec_no = 0;

  task automatic add(input logic r_, input logic t_, input logic p_, input logic [2:0] lamps,
                     input logic pe, input logic ack, input string nm);
    vec_t v;
    v.rst  = r_;
    v.tick = t_;
    v.ped  = p_;
    v.exp  = {lamps, pe, ack};
    v.nm   = nm;
    tbl.push_back(v);
  endtask

  task automatic rep(input int unsigned k, input logic t_, input logic p_, input logic [2:0] lamps,
                     input string nm);
    for (int unsigned i = 0; i < k; i++) add(1'b0, t_, p_, lamps, 1'b0, 1'b0, nm);
  endtask

  // Free-running schedule after a reset: a full cycle is 6 red + 8 green + 2 yellow = 16 ticks.
  task automatic add_run(input int unsigned cycles, input int unsigned period, input logic p_,
                         input string nm);
    int unsigned n = 0;
    int unsigned m;
    logic t;
    logic pe;
    logic [2:0] lamps;
    for (int unsigned c = 1; c <= cycles; c++) begin
      t  = ((c % period) == 0);
      pe = 1'b0;
      if (t) begin
        n++;
        pe = ((n % 16) == 0) || ((n % 16) == 6) || ((n % 16) == 14);
      end
      m = n % 16;
      lamps = (m < 6) ? LR : (m < 14) ? LG : LY;
      add(1'b0, t, p_, lamps, pe, 1'b0, nm);
    end
  endtask

  always @(posedge clk) begin
    vec_t e;
    logic [4:0] act;
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {red, yellow, green, phase_end, ped_ack};
      vec_no++;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s (vector %0d): got ryg/pe/ack=%b required %b", e.nm, vec_no, act, e.exp);
      end
    end
  end

  initial begin
    int unsigned wait_cycles;

    // reset held with tick high
    for (int unsigned i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, LR, 1'b0, 1'b0, "rst_with_tick");
    add_run(34, 1, 1'b0, "tick_held");
    add(1'b1, 1'b0, 1'b0, LR, 1'b0, 1'b0, "rst");
    add_run(70, 4, 1'b0, "tick_every4");

`ifndef TRAFFIC_LIGHT_CTRL_PED_REQ_EN
    add(1'b1, 1'b0, 1'b0, LR, 1'b0, 1'b0, "rst");
    add_run(20, 1, 1'b1, "ped_ignored_nomacro");
`endif

    // reset at the 5th green tick, with a request pending just before it
    add(1'b1, 1'b1, 1'b0, LR, 1'b0, 1'b0, "rst");
    rep(5, 1'b1, 1'b0, LR, "mid_rst_pre");
    add(1'b0, 1'b1, 1'b0, LG, 1'b1, 1'b0, "mid_rst_to_green");
    rep(4, 1'b1, 1'b0, LG, "mid_rst_green");
    add(1'b0, 1'b0, 1'b1, LG, 1'b0, 1'b0, "mid_rst_req");
    add(1'b1, 1'b1, 1'b0, LR, 1'b0, 1'b0, "mid_rst_hit");
    rep(5, 1'b1, 1'b0, LR, "mid_rst_cnt0");
    add(1'b0, 1'b1, 1'b0, LG, 1'b1, 1'b0, "mid_rst_green_again");
    rep(7, 1'b1, 1'b0, LG, "mid_rst_no_pend");
    add(1'b0, 1'b1, 1'b0, LY, 1'b1, 1'b0, "mid_rst_to_yellow");
    add(1'b0, 1'b1, 1'b0, LY, 1'b0, 1'b0, "mid_rst_yellow");
    add(1'b0, 1'b1, 1'b0, LR, 1'b1, 1'b0, "mid_rst_to_red_noack");

    // request during red is ignored
    add(1'b1, 1'b0, 1'b0, LR, 1'b0, 1'b0, "rst");
    rep(5, 1'b1, 1'b1, LR, "red_req");
    add(1'b0, 1'b1, 1'b1, LG, 1'b1, 1'b0, "red_req_to_green");
    rep(7, 1'b1, 1'b0, LG, "red_req_full_green");
    add(1'b0, 1'b1, 1'b0, LY, 1'b1, 1'b0, "red_req_to_yellow");
    add(1'b0, 1'b1, 1'b0, LY, 1'b0, 1'b0, "red_req_yellow");
    add(1'b0, 1'b1, 1'b0, LR, 1'b1, 1'b0, "red_req_to_red_noack");

    // request after the first green tick
    add(1'b1, 1'b0, 1'b0, LR, 1'b0, 1'b0, "rst");
    rep(5, 1'b1, 1'b0, LR, "ped_pre");
    add(1'b0, 1'b1, 1'b0, LG, 1'b1, 1'b0, "ped_to_green");
    add(1'b0, 1'b1, 1'b0, LG, 1'b0, 1'b0, "ped_green_tick1");
    add(1'b0, 1'b0, 1'b1, LG, 1'b0, 1'b0, "ped_req_pulse");
`ifdef TRAFFIC_LIGHT_CTRL_PED_REQ_EN
    add(1'b0, 1'b1, 1'b0, LY, 1'b1, 1'b0, "ped_short_green");
    add(1'b0, 1'b1, 1'b0, LY, 1'b0, 1'b0, "ped_yellow");
    add(1'b0, 1'b1, 1'b0, LR, 1'b1, 1'b1, "ped_ack_on_red");
    add(1'b0, 1'b0, 1'b0, LR, 1'b0, 1'b0, "ped_ack_one_cycle");

    // request coincident with a tick does not affect that tick
    add(1'b1, 1'b0, 1'b0, LR, 1'b0, 1'b0, "rst");
    rep(5, 1'b1, 1'b0, LR, "same_pre");
    add(1'b0, 1'b1, 1'b0, LG, 1'b1, 1'b0, "same_to_green");
    add(1'b0, 1'b1, 1'b0, LG, 1'b0, 1'b0, "same_green_tick1");
    add(1'b0, 1'b1, 1'b1, LG, 1'b0, 1'b0, "same_req_with_tick");
    add(1'b0, 1'b1, 1'b0, LY, 1'b1, 1'b0, "same_then_yellow");
    add(1'b0, 1'b1, 1'b0, LY, 1'b0, 1'b0, "same_yellow");
    add(1'b0, 1'b1, 1'b0, LR, 1'b1, 1'b1, "same_ack_on_red");
`else
    rep(6, 1'b1, 1'b0, LG, "ped_nomacro_green");
    add(1'b0, 1'b1, 1'b0, LY, 1'b1, 1'b0, "ped_nomacro_yellow");
    add(1'b0, 1'b1, 1'b0, LY, 1'b0, 1'b0, "ped_nomacro_yellow2");
    add(1'b0, 1'b1, 1'b0, LR, 1'b1, 1'b0, "ped_nomacro_red_noack");
`endif

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst     = tbl[i].rst;
      tick    = tbl[i].tick;
      ped_req = tbl[i].ped;
      exp_q.push_back(tbl[i]);
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 8) begin
      @(negedge clk);
      tick    = 1'b0;
      ped_req = 1'b0;
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d vectors unchecked, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
